// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory with byte/half/word access, alignment and range checking
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q, word, shifted, ext, wlane;
  logic [AW-1:0] idx;
  logic [3:0] be;
  logic err_q, err, accept;
  always_comb begin
    err = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) ||
          (req_size == 2'd2 && req_addr[1:0] != 2'd0) || req_addr[31:2] >= 30'(DEPTH_WORDS);
    idx = req_addr[AW+1:2];
    word = mem[idx];
    shifted = word >> {req_addr[1:0], 3'b000};
    ext = req_size == 2'd0 ? {{24{~req_unsigned & shifted[7]}}, shifted[7:0]} :
          req_size == 2'd1 ? {{16{~req_unsigned & shifted[15]}}, shifted[15:0]} : shifted;
    be = req_size == 2'd0 ? 4'b0001 << req_addr[1:0] :
         req_size == 2'd1 ? 4'b0011 << req_addr[1:0] : 4'b1111;
    wlane = req_size == 2'd0 ? {4{req_wdata[7:0]}} :
            req_size == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 3'd0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        rdata_q <= (err || req_we) ? '0 : ext;
        err_q <= err;
      end
    end
  end
  // storage is deliberately outside the reset domain so contents survive reset
  always_ff @(posedge clk)
    if (accept && req_we && !err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (state == WAIT) begin
      cnt_n = cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
      state_n = cnt == 3'd0 ? RESP : WAIT;
    end else if (state == RESP) state_n = IDLE;
    if (accept) begin
      state_n = LATENCY == 1 ? RESP : WAIT;
      cnt_n = LATENCY == 1 ? 3'd0 : 3'(LATENCY - 2);
    end
  end
  // outputs are gated by reset so an in-flight response is suppressed immediately
  always_comb begin
    req_ready = reset && state != WAIT;
    accept = req_valid && req_ready;
    resp_valid = reset && state == RESP;
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err = resp_valid && err_q;
    busy = reset && state != IDLE;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit storage words (power of two, 16..65536).
REQ-002 Parameter LATENCY, default 2, SHALL set the request-to-response latency in cycles (legal range 1..7).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-005 req_valid  input  1  SHALL indicate that the pipeline memory stage presents a request.
REQ-006 req_ready  output  1  SHALL indicate that the block can accept a request this cycle.
REQ-007 req_we  input  1  SHALL select the operation: 1 = store, 0 = load.
REQ-008 req_addr  input  32  SHALL be the byte address.
REQ-009 req_wdata  input  32  SHALL be the store data; bytes are taken from the low lanes.
REQ-010 req_size  input  2  SHALL be the access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-011 req_unsigned  input  1  SHALL select zero-extension (1) or sign-extension (0) of load data.
REQ-012 resp_valid  output  1  SHALL be a one-cycle pulse marking a completed request.
REQ-013 resp_rdata  output  32  SHALL carry the extended load data; 0 for stores and for errors.
REQ-014 resp_err  output  1  SHALL flag a faulted request; valid only while resp_valid = 1.
REQ-015 busy  output  1  SHALL be 1 whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 req_ready SHALL be 1 in IDLE and in RESP, and 0 in WAIT.
REQ-018 A request SHALL be accepted in any cycle where req_valid = 1 and req_ready = 1.
REQ-019 On accept, the FSM SHALL go to RESP if LATENCY = 1; otherwise it SHALL go to WAIT and load cnt = LATENCY-2.
REQ-020 In WAIT, the FSM SHALL decrement cnt and go to RESP after the cycle in which cnt = 0.
REQ-021 resp_valid SHALL be 1 exactly in cycle t+LATENCY for a request accepted in cycle t.
REQ-022 From RESP, the FSM SHALL go to IDLE if no request is accepted that cycle; an accept in RESP SHALL follow REQ-019.
REQ-023 Sustained throughput SHALL be one request per LATENCY cycles.
REQ-024 Misalignment SHALL raise an error: half access with addr[0] = 1, word access with addr[1:0] != 0, or req_size = 3.
REQ-025 An out-of-range address SHALL raise an error: addr[31:2] >= DEPTH_WORDS.
REQ-026 An errored request SHALL not modify storage and SHALL return resp_rdata = 0 with resp_err = 1.
REQ-027 Stores SHALL commit on the accepting clock edge, with little-endian byte lanes selected by addr[1:0] and size; unselected bytes are unchanged.
REQ-028 Loads SHALL sample storage on the accepting edge.
REQ-029 A load accepted in the cycle after a store to the same word SHALL return the new data.
REQ-030 Load data SHALL be extracted from the addressed lane and then zero- or sign-extended to 32 bits per req_unsigned.
REQ-031 Response fields SHALL be registered and held stable while resp_valid = 1; outside RESP they SHALL be 0.
REQ-032 Inputs SHALL be ignored when no accept occurs.

Reset
REQ-033 While reset = 0, outputs SHALL be: state = IDLE, cnt = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, busy = 0, req_ready = 0.
REQ-034 req_ready SHALL rise in the first cycle after reset returns to 1.
REQ-035 Reset asserted during WAIT or RESP SHALL abort the pending response, which SHALL never be emitted; an already committed store SHALL remain written.
REQ-036 Storage contents SHALL not be cleared by reset.

Verification
REQ-037 LATENCY = 2: store word 0xDEADBEEF to address 0x10 accepted in cycle 5 -> resp_valid = 1 in cycle 7, resp_err = 0, resp_rdata = 0; a load from 0x10 then returns 0xDEADBEEF.
REQ-038 Load byte from 0x13 with req_unsigned = 0 after REQ-037 -> resp_rdata = 0xFFFFFFDE; with req_unsigned = 1 -> 0x000000DE; load half from 0x12, signed -> 0xFFFFDEAD.
REQ-039 Store half to 0x11 -> resp_err = 1 and memory unchanged; load word from DEPTH_WORDS*4 -> resp_err = 1 and resp_rdata = 0.
REQ-040 LATENCY = 3 with req_valid held at 1 for 6 requests -> accepts occur every 3 cycles, one resp_valid pulse per request, in order, and req_ready = 0 throughout WAIT.
REQ-041 Reset = 0 for one cycle one cycle after accepting a store of 0x12345678 to 0x20 -> no resp_valid; after reset, a load from 0x20 returns 0x12345678.
